// File: rtl/lfsr_generator_mc_if.sv
// Stream bus carrying the concatenated multi-lane LFSR word.
// The master drives the word and its valid flag; the slave drives ready.
interface lfsr_generator_mc_if #(
    parameter int DW = 128
);
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;

    modport master (output dout, output dout_valid, input  dout_ready);
    modport slave  (input  dout, input  dout_valid, output dout_ready);
endinterface

// File: rtl/lfsr_generator_mc.sv
// Multi-lane Galois LFSR word source with a start/stop/burst controller.
// The lanes are streamed as one concatenated word over a valid/ready bus.
module lfsr_generator_mc #(
    parameter int               WIDTH          = 32,
    parameter int               LANES          = 4,
    parameter logic [WIDTH-1:0] TAPS           = WIDTH'(32'h80200003),
    parameter logic [WIDTH-1:0] SEED_DEFAULT   = WIDTH'(32'd1),
    parameter logic [WIDTH-1:0] LANE_SEED_STEP = WIDTH'(32'h9E3779B9)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             start,
    input  logic [15:0]      burst_len,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic [15:0]      word_count,
    lfsr_generator_mc_if.master stream
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] lane_step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : {WIDTH{1'b0}});
    endfunction

    // The all-zero state is a lock-up point of the LFSR, so it is replaced by 1.
    function automatic logic [WIDTH-1:0] lane_seed(input logic [WIDTH-1:0] base,
                                                   input int unsigned k);
        logic [WIDTH-1:0] v;
        v = base ^ (LANE_SEED_STEP * WIDTH'(k));
        return (v == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : v;
    endfunction

    state_t                 state_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   valid_r;
    logic [15:0]            word_count_r;
    logic [15:0]            len_r;
    logic [WIDTH-1:0]       lane_r      [LANES];
    logic [WIDTH-1:0]       lane_next_s [LANES];
    logic [WIDTH-1:0]       lane_seed_s [LANES];
    logic [LANES*WIDTH-1:0] dout_s;
    logic                   xfer_s;
    logic                   last_s;
    logic [15:0]            count_inc_s;

    // Next-step and reseed values per lane, plus the concatenated output word.
    always_comb begin
        dout_s = {(LANES*WIDTH){1'b0}};
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_next_s[k] = lane_step(lane_r[k]);
            lane_seed_s[k] = lane_seed(seed_in, k);
            dout_s[k*WIDTH +: WIDTH] = lane_r[k];
        end
    end

    // Transfer detection, saturating count increment and burst-end test.
    always_comb begin
        xfer_s = valid_r & stream.dout_ready;
        if (word_count_r == 16'hFFFF) begin
            count_inc_s = word_count_r;
        end else begin
            count_inc_s = word_count_r + 16'd1;
        end
        last_s = xfer_s && (len_r != 16'd0) && (count_inc_s == len_r);
    end

    // Controller FSM, lane registers and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            valid_r      <= 1'b0;
            word_count_r <= 16'd0;
            len_r        <= 16'd0;
            for (int unsigned k = 0; k < LANES; k++) begin
                lane_r[k] <= lane_seed(SEED_DEFAULT, k);
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Seed is applied in the same edge as start, so RUN opens on the new seed.
                    if (seed_load) begin
                        for (int unsigned k = 0; k < LANES; k++) begin
                            lane_r[k] <= lane_seed_s[k];
                        end
                    end
                    if (start) begin
                        state_r      <= ST_RUN;
                        busy_r       <= 1'b1;
                        valid_r      <= 1'b1;
                        len_r        <= burst_len;
                        word_count_r <= 16'd0;
                    end
                end
                ST_RUN: begin
                    if (xfer_s) begin
                        for (int unsigned k = 0; k < LANES; k++) begin
                            lane_r[k] <= lane_next_s[k];
                        end
                        word_count_r <= count_inc_s;
                    end
                    if (last_s || stop) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        valid_r <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy              = busy_r;
    assign done              = done_r;
    assign word_count        = word_count_r;
    assign stream.dout_valid = valid_r;
    assign stream.dout       = dout_s;

endmodule

// File: tb/tb_lfsr_generator_mc.sv
// Directed bench for lfsr_generator_mc with a queue-based scoreboard of expected words.
module tb_lfsr_generator_mc;

    localparam int            W     = 32;
    localparam int            L     = 4;
    localparam int            DW    = W * L;
    localparam logic [W-1:0]  TAPS  = 32'h80200003;
    localparam logic [W-1:0]  STEP  = 32'h9E3779B9;
    localparam logic [W-1:0]  SEED0 = 32'd1;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b1;
    logic          seed_load = 1'b0;
    logic [W-1:0]  seed_in   = 32'd0;
    logic          start     = 1'b0;
    logic [15:0]   burst_len = 16'd0;
    logic          stop      = 1'b0;
    logic          busy;
    logic          done;
    logic [15:0]   word_count;

    lfsr_generator_mc_if #(.DW(DW)) bus ();

    lfsr_generator_mc dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .start      (start),
        .burst_len  (burst_len),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .stream     (bus)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] exp_q[$];
    logic [W-1:0]  m_lane[L];
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_word;
    logic          pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    function automatic logic [W-1:0] m_step(input logic [W-1:0] s);
        logic [W-1:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ TAPS;
        return r;
    endfunction

    function automatic logic [W-1:0] m_seed(input logic [W-1:0] base, input int k);
        logic [W-1:0] v;
        v = base ^ W'(STEP * W'(k));
        if (v == 32'd0) v = 32'd1;
        return v;
    endfunction

    function automatic logic [DW-1:0] m_word();
        logic [DW-1:0] w;
        for (int k = 0; k < L; k++) w[k*W +: W] = m_lane[k];
        return w;
    endfunction

    task automatic m_reseed(input logic [W-1:0] base);
        for (int k = 0; k < L; k++) m_lane[k] = m_seed(base, k);
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(m_word());
            for (int k = 0; k < L; k++) m_lane[k] = m_step(m_lane[k]);
        end
    endtask

    // One cycle with the given ready: scores a transfer or remembers a stalled word.
    task automatic step(input logic rdy);
        bus.dout_ready = rdy;
        if (hold_pend) chk("hold", bus.dout, hold_word);
        hold_pend = 1'b0;
        if (bus.dout_valid) begin
            if (rdy) begin
                chk("q_avail", DW'(exp_q.size() != 0), DW'(1'b1));
                if (exp_q.size() != 0) chk("word", bus.dout, exp_q.pop_front());
            end else begin
                hold_pend = 1'b1;
                hold_word = bus.dout;
            end
        end
        tick();
    endtask

    task automatic begin_burst(input logic [15:0] len, input int n);
        start     = 1'b1;
        burst_len = len;
        tick();
        start     = 1'b0;
        chk("run_busy", DW'(busy), DW'(1'b1));
        chk("run_valid", DW'(bus.dout_valid), DW'(1'b1));
        chk("run_count0", DW'(word_count), DW'(16'd0));
        push_words(n);
    endtask

    task automatic end_check(input string tag, input logic [15:0] cnt);
        chk({tag, "_done"}, DW'(done), DW'(1'b1));
        chk({tag, "_valid"}, DW'(bus.dout_valid), DW'(1'b0));
        chk({tag, "_busy"}, DW'(busy), DW'(1'b0));
        chk({tag, "_count"}, DW'(word_count), DW'(cnt));
        chk({tag, "_qempty"}, DW'(exp_q.size()), DW'(0));
        tick();
        chk({tag, "_done_pulse"}, DW'(done), DW'(1'b0));
    endtask

    initial begin
        bus.dout_ready = 1'b0;
        m_reseed(SEED0);
        #1 reset_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", DW'(busy), DW'(1'b0));
        chk("rst_done", DW'(done), DW'(1'b0));
        chk("rst_valid", DW'(bus.dout_valid), DW'(1'b0));
        chk("rst_count", DW'(word_count), DW'(16'd0));
        chk("rst_dout", bus.dout, m_word());
        reset_n = 1'b1;
        tick();

        // Default burst of three words
        begin_burst(16'd3, 3);
        chk("b1_l1_w0", DW'(bus.dout[63:32]), DW'(32'h9E3779B8));
        chk("b1_l0_w0", DW'(bus.dout[31:0]), DW'(32'h00000001));
        step(1'b1);
        chk("b1_l0_w1", DW'(bus.dout[31:0]), DW'(32'h80200003));
        step(1'b1);
        chk("b1_l0_w2", DW'(bus.dout[31:0]), DW'(32'hC0300002));
        step(1'b1);
        end_check("b1", 16'd3);

        // Backpressure
        begin_burst(16'd4, 4);
        for (int i = 0; i < 7; i++) step(pat[i]);
        end_check("bp", 16'd4);

        // Seed load alone in IDLE becomes visible next cycle
        seed_in   = 32'h12345678;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        m_reseed(32'h12345678);
        chk("seed_vis", bus.dout, m_word());
        chk("seed_idle", DW'(bus.dout_valid), DW'(1'b0));

        // Zero seed together with start; seed_load and start during RUN are ignored
        seed_in   = 32'd0;
        seed_load = 1'b1;
        start     = 1'b1;
        burst_len = 16'd3;
        tick();
        seed_load = 1'b0;
        start     = 1'b0;
        m_reseed(32'd0);
        chk("seed0_l0", DW'(bus.dout[31:0]), DW'(32'h00000001));
        chk("seed0_l1", DW'(bus.dout[63:32]), DW'(32'h9E3779B9));
        push_words(3);
        seed_in   = 32'hDEADBEEF;
        seed_load = 1'b1;
        start     = 1'b1;
        burst_len = 16'd9;
        step(1'b1);
        step(1'b1);
        seed_load = 1'b0;
        start     = 1'b0;
        step(1'b1);
        end_check("seed", 16'd3);

        // Stop in IDLE is ignored
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("idle_stop_done", DW'(done), DW'(1'b0));
        chk("idle_stop_busy", DW'(busy), DW'(1'b0));

        // Continuous mode, stop together with the 101st transfer
        begin_burst(16'd0, 101);
        for (int i = 0; i < 100; i++) step(1'b1);
        chk("cont_count100", DW'(word_count), DW'(16'd100));
        stop = 1'b1;
        step(1'b1);
        stop = 1'b0;
        end_check("cont", 16'd101);

        // Asynchronous reset mid-burst
        begin_burst(16'd10, 10);
        step(1'b1);
        step(1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", DW'(bus.dout_valid), DW'(1'b0));
        chk("arst_busy", DW'(busy), DW'(1'b0));
        chk("arst_done", DW'(done), DW'(1'b0));
        chk("arst_count", DW'(word_count), DW'(16'd0));
        m_reseed(SEED0);
        chk("arst_dout", bus.dout, m_word());
        chk("arst_l0", DW'(bus.dout[31:0]), DW'(32'h00000001));
        exp_q.delete();
        hold_pend = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("arst_no_done", DW'(done), DW'(1'b0));
        chk("arst_idle", DW'(bus.dout_valid), DW'(1'b0));

        // Continuity across two bursts
        begin_burst(16'd2, 2);
        step(1'b1);
        step(1'b1);
        end_check("c1", 16'd2);
        begin_burst(16'd2, 2);
        chk("c2_l0_w0", DW'(bus.dout[31:0]), DW'(32'hC0300002));
        step(1'b1);
        chk("c2_l0_w1", DW'(bus.dout[31:0]), DW'(32'h60180001));
        step(1'b1);
        end_check("c2", 16'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_generator_mc.md
# lfsr_generator_mc

Multi-lane, parametrised pseudo-random word source for heater and link-test datapaths. Runs `LANES` independent Galois LFSRs of `WIDTH` bits each, with a shared runtime seed and a distinct seed per lane. Streams the lanes as one concatenated word over a valid/ready interface. A start/stop/burst controller produces either a fixed number of words or a continuous stream.

## Interface
- `WIDTH`, 32: bits per lane LFSR (2..64).
- `LANES`, 4: number of parallel lanes (1..16).
- `TAPS`, 32'h80200003: Galois feedback mask, `WIDTH` bits. The default is maximal-length for `WIDTH`=32.
- `SEED_DEFAULT`, 1: base seed applied at reset.
- `LANE_SEED_STEP`, 32'h9E3779B9: per-lane seed offset, `WIDTH` bits.
- `clk` in 1: sole clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `seed_load` in 1: load `seed_in` as the base seed; honoured only in IDLE.
- `seed_in` in `WIDTH`: runtime base seed.
- `start` in 1: begin a burst; honoured only in IDLE.
- `burst_len` in 16: words per burst, sampled on accepted `start`; 0 = continuous.
- `stop` in 1: abort the current burst.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse when a burst completes or is stopped.
- `word_count` out 16: transfers in the current or last burst.
- `dout_valid` out 1: output word valid.
- `dout_ready` in 1: downstream accepts the word.
- `dout` out `LANES*WIDTH`: lane k occupies bits [k*WIDTH +: WIDTH].

## Operation
- **Lane update:** `next = (s >> 1) ^ (s[0] ? TAPS : 0)`. Each lane updates independently.
- **Lane seed:** lane k seed = `base ^ (k * LANE_SEED_STEP)`, truncated to `WIDTH`. If the result is all-zero, the lane is forced to 1. The all-zero state is never loaded.
- **Reset:** lanes hold the seeds derived from `SEED_DEFAULT`. FSM = IDLE; `busy`=0, `done`=0, `dout_valid`=0, `word_count`=0.
- **FSM states:** IDLE and RUN.
- **IDLE → RUN:** on `start`. `burst_len` is latched, `word_count` is cleared, `busy`=1.
- **RUN → IDLE (burst end):** on the transfer that makes `word_count` == latched `burst_len` (`burst_len`≠0). `done` pulses.
- **RUN → IDLE (stop):** on `stop`. `done` pulses.
- **Transfers:**
  - `dout` is the current lane state, driven straight from the lane registers. `dout_valid` = (state == RUN).
  - A transfer is a cycle with `dout_valid` && `dout_ready`.
  - On a transfer, every lane advances one step and `word_count` increments. `word_count` saturates at 16'hFFFF in continuous mode.
  - With no transfer, lanes and `dout` hold: stable under backpressure.
- **`seed_load` in IDLE:** reseeds all lanes next cycle. If asserted together with `start`, the seed is applied first. RUN begins next cycle with the new seed, so the first word is the new lane seed.
- **`seed_load` and `start` in RUN:** ignored.
- **Stream continuity:** lanes are not reseeded between bursts. A new burst continues the sequence where the previous one stopped.
- **`stop` together with a transfer:** the transfer counts, then the FSM goes to IDLE.
- **`stop` on the final transfer:** a single `done` pulse.
- **`stop` in IDLE:** ignored.
- **`reset_n` low mid-burst:** all registers return to reset values immediately. No `done` pulse is generated.

## Timing
- `start` at cycle N → `dout_valid`=1 and `busy`=1 at N+1, first word = current lane state.
- The final transfer at cycle M → `dout_valid`=0, `busy`=0 and `done`=1 at M+1.
- `done` is high for exactly one cycle.
- `stop` at cycle N → `dout_valid`=0 at N+1.
- `seed_load` at N → new lane values visible on `dout` at N+1, and at the first RUN cycle.
- Throughput: one word per cycle while `dout_ready` is held high.
- Single register stage, no combinational path from `dout_ready` to `dout_valid`.

## Test plan
- **Reset and default burst:** reset, `start` with `burst_len`=3, `dout_ready`=1.
  - Lane 0 = 0x00000001, 0x80200003, 0xC0300002.
  - Lane 1 first word = 0x9E3779B8.
  - `done` pulses the cycle after the third word; `word_count`=3.
- **Backpressure:** `burst_len`=4, toggle `dout_ready` 1,0,0,1,1,0,1.
  - `dout` holds while ready=0.
  - Exactly 4 words, in the same sequence as uninterrupted.
  - `word_count`=4.
- **Seed load:** `seed_in`=0 in IDLE.
  - Lane 0 first word = 0x00000001 (zero guard).
  - Lane 1 = 0x9E3779B9.
  - `seed_load` during RUN has no effect on the stream.
- **Continuous mode and stop:** `burst_len`=0, run 100 transfers, then `stop` together with a transfer.
  - `word_count`=101.
  - One `done` pulse; `dout_valid`=0 next cycle.
- **Continuity:** two bursts of 2 words each.
  - Second burst yields 0xC0300002, 0x60180001 on lane 0.
- **Async reset:** drop `reset_n` mid-burst asynchronously.
  - `dout_valid`, `busy` and `done` go to 0 without waiting for a clock edge.
  - Lanes return to the `SEED_DEFAULT` seeds; no `done` pulse.
